// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Moore serial-pattern detector with a runtime-programmable pattern of
// 1..MAX_LEN bits and runtime-selectable overlapping/non-overlapping matching.
// Configuration is captured into shadow registers while the detector is
// disabled and frozen while it is enabled.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   en           detector enable; config shadows hold while high
//   in_valid     qualifies x for this cycle
//   x            serial data bit
//   cfg_pattern  pattern; bit [cfg_len-1] is the first bit received
//   cfg_len      pattern length; 0 acts as 1, >MAX_LEN acts as MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   count_clr    synchronous clear of match_count (wins over a hit)
//   z            Moore match flag, high while in MATCH
//   match_pulse  one-cycle pulse per hit
//   match_count  saturating hit counter
//   state        current state: 00 IDLE, 01 HUNT, 10 MATCH
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic               x,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               z,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HUNT  = 2'b01,
        MATCH = 2'b10
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] len_mask;
    logic               accept;
    logic               hit;

    // Shift left so the oldest bit moves toward the MSB, matching the
    // pattern convention where bit [L-1] is the first bit received.
    assign hist_next = {hist_q[MAX_LEN-2:0], x};
    assign fill_next = (fill_q == MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;

    assign len_clamped = (cfg_len == '0)       ? LEN_W'(1)  :
                         (cfg_len > MAX_LEN_L) ? MAX_LEN_L  : cfg_len;

    // Low L bits set; a shift by MAX_LEN yields all ones after inversion.
    assign len_mask = ~({MAX_LEN{1'b1}} << len_q);

    // The cycle en rises from IDLE is spent entering HUNT, so no bit is taken.
    assign accept = en && in_valid && (state_q != IDLE);
    assign hit    = accept && (fill_next >= len_q) &&
                    (((hist_next ^ pat_q) & len_mask) == '0);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        pulse_d = hit;

        if (!en) begin
            pat_d   = cfg_pattern;
            len_d   = len_clamped;
            ovl_d   = cfg_overlap;
            state_d = IDLE;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = HUNT;
                HUNT, MATCH: begin
                    if (accept) begin
                        hist_d  = hist_next;
                        // Non-overlap mode forces the next match to need L fresh bits.
                        fill_d  = (hit && !ovl_q) ? '0 : fill_next;
                        state_d = hit ? MATCH : HUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            ovl_q   <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign z           = (state_q == MATCH);
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param (MAX_LEN=8, CNT_W=2). Each scenario
// task drives its own vectors and compares against hand-computed values.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// that same point, so every check reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic               x;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               z;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic [1:0]         state;

    int errors = 0;
    int checks = 0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .x          (x),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .count_clr  (count_clr),
        .z          (z),
        .match_pulse(match_pulse),
        .match_count(match_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Hard stop in case something upstream stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load config while disabled, clear the counter, then enable (IDLE->HUNT).
    task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                             input logic ovl);
        in_valid    = 1'b0;
        en          = 1'b0;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        count_clr   = 1'b1;
        tick();
        count_clr   = 1'b0;
        en          = 1'b1;
        tick();
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        x        = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; x = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
        #12;
        checks++;
        if ({z, match_pulse, match_count, state} !== 6'b0) begin
            $display("[TB] FAIL reset_outputs: got z=%b p=%b cnt=%0d st=%b, want all 0",
                     z, match_pulse, match_count, state);
            errors++;
        end
        #3 rst = 1'b1;
        tick();
        checks++;
        if (state !== 2'b00) begin
            $display("[TB] FAIL reset_idle: got st=%b want 00", state);
            errors++;
        end
    endtask

    task automatic test_overlap();
        logic [6:0] stream = 7'b1001001;
        logic [6:0] expz   = 7'b0001001;
        configure(8'b0000_1001, 4'd4, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z !== expz[i] || match_pulse !== expz[i]) begin
                $display("[TB] FAIL overlap_bit%0d: got z=%b p=%b want %b", 7 - i, z,
                         match_pulse, expz[i]);
                errors++;
            end
        end
        checks++;
        if (match_count !== 2'd2) begin
            $display("[TB] FAIL overlap_count: got %0d want 2", match_count);
            errors++;
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] stream = 7'b1001001;
        logic [6:0] expz   = 7'b0001000;
        configure(8'b0000_1001, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z !== expz[i] || match_pulse !== expz[i]) begin
                $display("[TB] FAIL nonoverlap_bit%0d: got z=%b p=%b want %b", 7 - i, z,
                         match_pulse, expz[i]);
                errors++;
            end
        end
        checks++;
        if (match_count !== 2'd1) begin
            $display("[TB] FAIL nonoverlap_count: got %0d want 1", match_count);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expz = 4'b0111;
        configure(8'b0000_0011, 4'd2, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            send_bit(1'b1);
            checks++;
            if (z !== expz[i] || match_pulse !== expz[i]) begin
                $display("[TB] FAIL b2b_bit%0d: got z=%b p=%b want %b", 4 - i, z,
                         match_pulse, expz[i]);
                errors++;
            end
        end
        checks++;
        if (match_count !== 2'd3) begin
            $display("[TB] FAIL b2b_count: got %0d want 3", match_count);
            errors++;
        end
    endtask

    task automatic test_gaps();
        logic [3:0] stream = 4'b1001;
        logic [3:0] expz   = 4'b0001;
        configure(8'b0000_1001, 4'd4, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z !== expz[i] || match_pulse !== expz[i]) begin
                $display("[TB] FAIL gaps_bit%0d: got z=%b p=%b want %b", 4 - i, z,
                         match_pulse, expz[i]);
                errors++;
            end
            for (int g = 0; g < 3; g++) begin
                tick();
                checks++;
                if (z !== expz[i] || match_pulse !== 1'b0) begin
                    $display("[TB] FAIL gaps_idle%0d_%0d: got z=%b p=%b want z=%b p=0",
                             4 - i, g, z, match_pulse, expz[i]);
                    errors++;
                end
            end
        end
        send_bit(1'b0);
        checks++;
        if (z !== 1'b0 || match_count !== 2'd1) begin
            $display("[TB] FAIL gaps_tail: got z=%b cnt=%0d want z=0 cnt=1", z, match_count);
            errors++;
        end
    endtask

    task automatic test_config_freeze();
        configure(8'b0000_1001, 4'd4, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        cfg_pattern = 8'b0000_0110;
        send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if (z !== 1'b1 || state !== 2'b10) begin
            $display("[TB] FAIL freeze_old_hit: got z=%b st=%b want z=1 st=10", z, state);
            errors++;
        end
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (z !== 1'b0) begin
            $display("[TB] FAIL freeze_new_ignored: got z=%b want 0", z);
            errors++;
        end
        en = 1'b0;
        tick();
        checks++;
        if (state !== 2'b00) begin
            $display("[TB] FAIL freeze_idle: got st=%b want 00", state);
            errors++;
        end
        en = 1'b1;
        tick();
        checks++;
        if (state !== 2'b01) begin
            $display("[TB] FAIL freeze_hunt: got st=%b want 01", state);
            errors++;
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (z !== 1'b1 || match_pulse !== 1'b1) begin
            $display("[TB] FAIL freeze_new_hit: got z=%b p=%b want 1 1", z, match_pulse);
            errors++;
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] stream = 4'b1001;
        logic [3:0] expz   = 4'b0001;
        configure(8'b0000_1001, 4'd4, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        for (int i = 3; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z !== expz[i]) begin
                $display("[TB] FAIL endrop_bit%0d: got z=%b want %b", 4 - i, z, expz[i]);
                errors++;
            end
        end
    endtask

    task automatic test_long_clamp();
        logic [7:0] stream = 8'hA5;
        logic [7:0] expz   = 8'b0000_0001;
        configure(8'hA5, 4'd15, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z !== expz[i]) begin
                $display("[TB] FAIL clamp_bit%0d: got z=%b want %b", 8 - i, z, expz[i]);
                errors++;
            end
        end
    endtask

    task automatic test_counter();
        logic [1:0] expc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        // len 0 acts as 1; pattern bit 0 = 1 so every accepted 1 is a hit.
        en = 1'b0; in_valid = 1'b0;
        cfg_pattern = 8'b0000_0001; cfg_len = 4'd0; cfg_overlap = 1'b1;
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        en = 1'b1; in_valid = 1'b1; x = 1'b1;
        tick();
        checks++;
        if (state !== 2'b01 || match_pulse !== 1'b0 || match_count !== 2'd0) begin
            $display("[TB] FAIL rise_no_accept: got st=%b p=%b cnt=%0d want 01 0 0",
                     state, match_pulse, match_count);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (match_count !== expc[i] || match_pulse !== 1'b1) begin
                $display("[TB] FAIL sat_hit%0d: got cnt=%0d p=%b want cnt=%0d p=1", i + 1,
                         match_count, match_pulse, expc[i]);
                errors++;
            end
        end
        count_clr = 1'b1;
        tick();
        checks++;
        if (match_count !== 2'd0 || match_pulse !== 1'b1) begin
            $display("[TB] FAIL clr_vs_hit: got cnt=%0d p=%b want cnt=0 p=1", match_count,
                     match_pulse);
            errors++;
        end
        count_clr = 1'b0;
        tick();
        checks++;
        if (match_count !== 2'd1) begin
            $display("[TB] FAIL after_clr: got cnt=%0d want 1", match_count);
            errors++;
        end
        x = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (z !== 1'b0 || match_count !== 2'd1) begin
            $display("[TB] FAIL l1_miss: got z=%b cnt=%0d want z=0 cnt=1", z, match_count);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        configure(8'b0000_0001, 4'd1, 1'b1);
        send_bit(1'b1);
        checks++;
        if (z !== 1'b1 || match_pulse !== 1'b1 || match_count !== 2'd1) begin
            $display("[TB] FAIL prereset_hit: got z=%b p=%b cnt=%0d want 1 1 1", z,
                     match_pulse, match_count);
            errors++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({z, match_pulse, match_count, state} !== 6'b0) begin
            $display("[TB] FAIL async_reset: got z=%b p=%b cnt=%0d st=%b want all 0",
                     z, match_pulse, match_count, state);
            errors++;
        end
        #3 rst = 1'b1;
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_back_to_back();
        test_gaps();
        test_config_freeze();
        test_en_drop();
        test_long_clamp();
        test_counter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore serial-pattern detector, the successor to the fixed-pattern detectors in our serial front end. It scans a qualified 1-bit stream for a runtime-programmable pattern of 1..MAX_LEN bits, with overlapping or non-overlapping match mode selected at runtime. It holds a Moore match flag, emits a single-cycle match pulse, and keeps a saturating match counter for status readback.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width in bits
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
en  input  1  detector enable; config is frozen while high
in_valid  input  1  qualifies x for this cycle
x  input  1  serial data bit
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received
cfg_len  input  LEN_W  pattern length; 0 is treated as 1, values >MAX_LEN as MAX_LEN
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
count_clr  input  1  synchronous clear of match_count
z  output  1  Moore match flag (high while in MATCH)
match_pulse  output  1  one-cycle pulse per match
match_count  output  CNT_W  saturating count of matches
state  output  2  current state: 00 IDLE, 01 HUNT, 10 MATCH

Behaviour:
- Reset (rst=0, async): state=IDLE, z=0, match_pulse=0, match_count=0, history=0, fill=0, shadow config = (pattern 0, len 1, overlap 0).
- Shadow config: while en=0, the shadow registers load cfg_pattern, clamped cfg_len and cfg_overlap every cycle. While en=1 they hold; cfg_* changes are ignored.
- History: a MAX_LEN shift register. On each accepted bit (en=1, in_valid=1) it shifts left with x entering at bit 0. The fill counter (0..MAX_LEN) increments and saturates at MAX_LEN.
- Hit condition, evaluated on an accepted bit using the post-shift history: fill_next >= L and hist_next[L-1:0] == pattern[L-1:0], where L is the shadow length.
- States:
  - IDLE: entered when en=0. Clears history and fill; z=0. On en=1 -> HUNT next cycle. Bits are not accepted in the cycle en rises from IDLE.
  - HUNT: on an accepted bit with a hit -> MATCH; otherwise stay in HUNT.
  - MATCH: z=1. On an accepted bit with a hit -> stay in MATCH (match_pulse fires again). On an accepted bit without a hit -> HUNT. With no accepted bit -> stay in MATCH; z holds high.
  - Any state with en=0 -> IDLE on the next edge.
- Non-overlap mode: on a hit, fill is set to 0 instead of incrementing, so the next match needs L fresh bits. Overlap mode: fill is not reset.
- Latency: z and match_pulse go high in the cycle after the clock edge that samples the completing bit; both are registered.
- match_pulse: high for exactly one cycle per hit, including back-to-back hits.
- match_count:
  - Increments by 1 per hit and saturates at 2^CNT_W-1.
  - count_clr has priority: if count_clr and a hit occur in the same cycle, the result is 0.
  - Unaffected by en; cleared only by count_clr or rst.
- in_valid=0: history, fill and state hold; match_pulse=0.
- en dropped mid-pattern: partial history is discarded; detection restarts from empty after re-enable.
- Reset mid-operation: all outputs return to their reset values immediately, without waiting for a clock edge.
- L=1: every accepted bit equal to pattern[0] is a hit.

Test Plan:
- Overlap mode, L=4, pattern 4'b1001, stream 1,0,0,1,0,0,1 (valid every cycle) -> hits on bits 4 and 7; match_count=2; z high after bit 4, low after bit 5, high after bit 7.
- Non-overlap mode, same pattern and stream -> single hit on bit 4; match_count=1; z=0 after bit 5 and stays low.
- Overlap mode, L=2, pattern 2'b11, stream 1,1,1,1 -> hits on bits 2, 3 and 4; match_pulse high for 3 consecutive cycles; z held high.
- Gaps: stream 1001 with in_valid=0 for 3 cycles between each bit -> exactly one hit; z stays high through trailing invalid cycles until the next valid 0.
- Config freeze: with en=1, change cfg_pattern to 4'b0110 mid-stream -> detection still uses 1001. Drop en, reprogram, raise en -> state 00 -> 01 and new pattern is active.
- Counter and reset: CNT_W=2, 5 hits -> count saturates at 3. count_clr coincident with a hit -> count=0. rst=0 asserted mid-pattern -> z, match_pulse, count and state go to 0 asynchronously.
